// File: rtl/seq_divider32_pkg.sv
// Shared definitions for the sequential 32-bit divider: sizes, FSM states,
// special-case result constants and operand helper functions.
package div_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DIV0_QUOT  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] SIGNED_MIN = 32'h8000_0000;

    // Absolute value of a two's-complement operand when signed mode is on;
    // unsigned operands pass through. The most negative value maps to its
    // own bit pattern, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        logic [WIDTH-1:0] res;
        if (sgn && v[WIDTH-1]) begin
            res = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Two's-complement negation used by the sign fix-up.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/seq_divider32_if.sv
// Start/done request and result bundle between a requester and the divider.
interface seq_divider32_if;
    import div_pkg::*;

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider32_sub_step.sv
// Trial subtractor for one restoring-division iteration: r - d computed as
// r + ~d + 1; the carry out doubles as the "result is non-negative" flag.
module div_sub_step
    import div_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W:0]   r,
    input  logic [W-1:0] d,
    output logic [W:0]   diff,
    output logic         non_neg
);

    logic [W+1:0] sum_s;

    // Add of the inverted, zero-extended divisor with carry-in of one.
    always_comb begin
        sum_s   = {1'b0, r} + {1'b0, ~{1'b0, d}} + {{(W+1){1'b0}}, 1'b1};
        diff    = sum_s[W:0];
        non_neg = sum_s[W+1];
    end

endmodule

// File: rtl/seq_divider32.sv
// Iterative restoring divider, signed/unsigned, fixed 33-cycle latency from
// accepted start to the done pulse. One quotient bit is produced per cycle.
module seq_divider32
    import div_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    seq_divider32_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] dvd_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             zero_r;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   diff_s;
    logic             non_neg_s;
    logic [WIDTH-1:0] fin_q_s;
    logic [WIDTH-1:0] fin_r_s;
    logic             unused_s;

    // {R,Q} shifted left by one: next quotient-register MSB enters R.
    assign shift_s = {rem_r, quo_r[WIDTH-1]};

    div_sub_step #(.W(WIDTH)) u_sub (
        .r       (shift_s),
        .d       (dvs_r),
        .diff    (diff_s),
        .non_neg (non_neg_s)
    );

    // A successful trial always leaves R below the divisor, so the top
    // difference bit is zero whenever it is kept.
    assign unused_s = diff_s[WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: fixed WIDTH iterations regardless of operands.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    next_state_s = CALC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == LAST_ITER) begin
                    next_state_s = FIN;
                end else begin
                    next_state_s = CALC;
                end
            end
            FIN:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Sign fix-up and divide-by-zero override of the raw magnitude results.
    always_comb begin
        fin_q_s = quo_r;
        fin_r_s = rem_r;
        if (zero_r) begin
            fin_q_s = DIV0_QUOT;
            fin_r_s = dvd_r;
        end else begin
            fin_q_s = neg_q_r ? negate(quo_r) : quo_r;
            fin_r_s = neg_r_r ? negate(rem_r) : rem_r;
        end
    end

    // Operand latch, per-cycle iteration and result/handshake registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r       <= {CNT_W{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            dvd_r       <= {WIDTH{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            zero_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        busy_r  <= 1'b1;
                        cnt_r   <= {CNT_W{1'b0}};
                        rem_r   <= {WIDTH{1'b0}};
                        quo_r   <= magnitude(bus.dividend, bus.is_signed);
                        dvs_r   <= magnitude(bus.divisor, bus.is_signed);
                        dvd_r   <= bus.dividend;
                        neg_q_r <= bus.is_signed &
                                   (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        neg_r_r <= bus.is_signed & bus.dividend[WIDTH-1];
                        zero_r  <= (bus.divisor == {WIDTH{1'b0}});
                    end
                end
                CALC: begin
                    rem_r <= non_neg_s ? diff_s[WIDTH-1:0] : shift_s[WIDTH-1:0];
                    quo_r <= {quo_r[WIDTH-2:0], non_neg_s};
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                FIN: begin
                    quotient_r  <= fin_q_s;
                    remainder_r <= fin_r_s;
                    dbz_r       <= zero_r;
                    done_r      <= 1'b1;
                    busy_r      <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;

endmodule
